// File: rtl/mul_share_sched.sv
// Round-robin scheduler sharing one fixed-latency pipelined multiplier among NREQ requesters,
// with an ID tag pipe and a credit-protected show-ahead response FIFO.
module mul_share_sched #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned WA     = 16,
  parameter int unsigned WB     = 16,
  parameter int unsigned LAT    = 4,
  parameter int unsigned FDEPTH = 8,
  localparam int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ*WA-1:0]            req_a,
  input  logic [NREQ*WB-1:0]            req_b,
  output logic                          mul_valid_in,
  output logic [WA-1:0]                 mul_a,
  output logic [WB-1:0]                 mul_b,
  input  logic                          mul_valid_out,
  input  logic [WA+WB-1:0]              mul_p,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [IDW-1:0]                rsp_id,
  output logic [WA+WB-1:0]              rsp_p,
  output logic [$clog2(FDEPTH+1)-1:0]   inflight,
  output logic                          err
);
  localparam int unsigned CW  = $clog2(FDEPTH+1);
  localparam int unsigned PW  = $clog2(FDEPTH);
  localparam int unsigned PRW = WA + WB;

  logic [IDW-1:0]     last, issue_id, gid;
  logic [NREQ-1:0]    grant;
  logic               found, can_issue, accept;
  logic [WA-1:0]      sel_a;
  logic [WB-1:0]      sel_b;
  int unsigned        idx;
  logic               tag_v  [LAT];
  logic [IDW-1:0]     tag_id [LAT];
  logic [CW-1:0]      count;
  logic [PW-1:0]      wptr, rptr, rnext;
  logic [IDW+PRW-1:0] mem [FDEPTH];
  logic [IDW+PRW-1:0] pdata;
  logic               exit_v, push, pop, full;

  // Credit covers every issued-but-unpopped result, so the FIFO can never overflow.
  assign can_issue = ({1'b0, inflight} + {1'b0, count}) < (CW+1)'(FDEPTH);
  assign exit_v    = tag_v[LAT-1];
  assign push      = mul_valid_out & exit_v;
  assign pop       = rsp_valid & rsp_ready;
  assign full      = (count == CW'(FDEPTH));
  assign rsp_valid = (count != '0);
  assign rnext     = rptr + PW'(1);
  assign pdata     = {tag_id[LAT-1], mul_p};

  always_comb begin
    grant = '0;
    gid   = '0;
    found = 1'b0;
    sel_a = '0;
    sel_b = '0;
    idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(last) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gid        = IDW'(idx);
        sel_a      = req_a[idx*WA +: WA];
        sel_b      = req_b[idx*WB +: WB];
      end
    end
    req_ready = can_issue ? grant : '0;
    accept    = can_issue & found;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last         <= IDW'(NREQ-1);
      mul_valid_in <= 1'b0;
      mul_a        <= '0;
      mul_b        <= '0;
      issue_id     <= '0;
      for (int unsigned k = 0; k < LAT; k++) begin
        tag_v[k]  <= 1'b0;
        tag_id[k] <= '0;
      end
      inflight     <= '0;
      err          <= 1'b0;
      count        <= '0;
      wptr         <= '0;
      rptr         <= '0;
      rsp_id       <= '0;
      rsp_p        <= '0;
    end else begin
      mul_valid_in <= accept;
      if (accept) begin
        last     <= gid;
        mul_a    <= sel_a;
        mul_b    <= sel_b;
        issue_id <= gid;
      end
      tag_v[0]  <= mul_valid_in;
      tag_id[0] <= issue_id;
      for (int unsigned k = 1; k < LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
      inflight <= inflight + CW'(accept) - CW'(exit_v);
      err      <= err | (mul_valid_out ^ exit_v);
      count    <= count + CW'(push) - CW'(pop);
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rnext;
      // Output registers track the next head; they hold when the FIFO drains empty.
      if (pop) begin
        if (count > CW'(1))  {rsp_id, rsp_p} <= mem[rnext];
        else if (push)       {rsp_id, rsp_p} <= pdata;
      end else if (count == '0 && push) begin
        {rsp_id, rsp_p} <= pdata;
      end
      assert (!(push && full && !pop));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= pdata;
  end
endmodule
